// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: clear-FSM state
// encoding and the packed-port slice helper.
package regfile_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Lowest bit index of port k inside a packed bus of w-bit slices.
  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential sweep-clear engine: walks a pointer over every register, one
// entry per cycle, so the array can be zeroed without a global reset.
// Ports:
//   Clock, Reset_n        clock and async active-low reset
//   ClearReq              start a sweep (honoured only in IDLE)
//   ClearBusy             registered, high while sweeping
//   ClearDone             registered, one-cycle pulse after the sweep
//   sweep_en, sweep_addr  zero-write request towards the array
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              ClearReq,
  output logic              ClearBusy,
  output logic              ClearDone,
  output logic              sweep_en,
  output logic [ADDR_W-1:0] sweep_addr
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // State, pointer and flag registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; flags are derived from the next state so they are
  // registered yet track the state exactly.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ClearReq) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (ptr_q == PTR_LAST) begin
          state_d = ST_DONE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_SWEEP);
    done_d = (state_d == ST_DONE);
  end

  assign ClearBusy  = busy_q;
  assign ClearDone  = done_q;
  assign sweep_en   = busy_q;
  assign sweep_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports with same-cycle
// write bypass, two prioritised write ports (port 1 wins) and a sweep clear.
// Ports:
//   Clock, Reset_n                       clock and async active-low reset
//   ReadAddr / ReadData                  packed read ports, slice k = port k
//   WriteEn0/WriteAddr0/WriteData0       write port 0 (low priority)
//   WriteEn1/WriteAddr1/WriteData1       write port 1 (high priority)
//   ClearReq / ClearBusy / ClearDone     sweep-clear control and status
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] ReadAddr,
  output logic [NUM_RD*DATA_W-1:0] ReadData,
  input  logic                     WriteEn0,
  input  logic [ADDR_W-1:0]        WriteAddr0,
  input  logic [DATA_W-1:0]        WriteData0,
  input  logic                     WriteEn1,
  input  logic [ADDR_W-1:0]        WriteAddr1,
  input  logic [DATA_W-1:0]        WriteData1,
  input  logic                     ClearReq,
  output logic                     ClearBusy,
  output logic                     ClearDone
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              sweep_en;
  logic [ADDR_W-1:0] sweep_addr;
  logic              we0_ok, we1_ok;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .ClearReq   (ClearReq),
    .ClearBusy  (ClearBusy),
    .ClearDone  (ClearDone),
    .sweep_en   (sweep_en),
    .sweep_addr (sweep_addr)
  );

  // Writes to the hardwired zero register are dropped at the source.
  assign we0_ok = WriteEn0 && !((ZERO_REG != 0) && (WriteAddr0 == '0));
  assign we1_ok = WriteEn1 && !((ZERO_REG != 0) && (WriteAddr1 == '0));

  // Array update: port 1 over port 0 over the sweep zero.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (we1_ok && (WriteAddr1 == ADDR_W'(i)))
          regs[i] <= WriteData1;
        else if (we0_ok && (WriteAddr0 == ADDR_W'(i)))
          regs[i] <= WriteData0;
        else if (sweep_en && (sweep_addr == ADDR_W'(i)))
          regs[i] <= '0;
      end
    end
  end

  // Read ports with write bypass; the sweep is deliberately not bypassed.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    localparam int unsigned ALO = slice_lo(k, ADDR_W);
    localparam int unsigned DLO = slice_lo(k, DATA_W);

    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = ReadAddr[ALO +: ADDR_W];

    always_comb begin
      rd = regs[ra];
      if ((ZERO_REG != 0) && (ra == '0))
        rd = '0;
      else if (WriteEn1 && (ra == WriteAddr1))
        rd = WriteData1;
      else if (WriteEn0 && (ra == WriteAddr0))
        rd = WriteData0;
    end

    assign ReadData[DLO +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (three read ports, 32 x 32).
module tb_regfile_mp;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NR    = 3;
  localparam int unsigned DEPTH = 32;

  logic             Clock;
  logic             Reset_n;
  logic [NR*AW-1:0] ReadAddr;
  logic [NR*DW-1:0] ReadData;
  logic             WriteEn0, WriteEn1;
  logic [AW-1:0]    WriteAddr0, WriteAddr1;
  logic [DW-1:0]    WriteData0, WriteData1;
  logic             ClearReq, ClearBusy, ClearDone;

  int checks   = 0;
  int failures = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .ReadAddr   (ReadAddr),
    .ReadData   (ReadData),
    .WriteEn0   (WriteEn0),
    .WriteAddr0 (WriteAddr0),
    .WriteData0 (WriteData0),
    .WriteEn1   (WriteEn1),
    .WriteAddr1 (WriteAddr1),
    .WriteData1 (WriteData1),
    .ClearReq   (ClearReq),
    .ClearBusy  (ClearBusy),
    .ClearDone  (ClearDone)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a);
    ReadAddr = {a, a, a};
    #1;
  endtask

  int busy_cnt, done_cnt, done_at;

  initial begin
    Reset_n    = 1'b0;
    ReadAddr   = '0;
    WriteEn0   = 1'b0; WriteAddr0 = '0; WriteData0 = '0;
    WriteEn1   = 1'b0; WriteAddr1 = '0; WriteData1 = '0;
    ClearReq   = 1'b0;

    // Reset state.
    repeat (3) @(posedge Clock);
    #1;
    check("rst_busy", DW'(ClearBusy), 32'h0);
    check("rst_done", DW'(ClearDone), 32'h0);
    Reset_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(AW'(a));
      check("rst_read", ReadData[DW-1:0], 32'h0);
    end

    // Zero register: bypass and stored value both read 0.
    WriteEn1 = 1'b1; WriteAddr1 = 5'd0; WriteData1 = 32'hDEADBEEF;
    set_rd(5'd0);
    check("zero_bypass", ReadData[DW-1:0], 32'h0);
    step();
    WriteEn1 = 1'b0;
    set_rd(5'd0);
    check("zero_stored", ReadData[DW-1:0], 32'h0);

    // Same-address collision: port 1 wins, in-cycle and stored.
    WriteEn0 = 1'b1; WriteAddr0 = 5'd5; WriteData0 = 32'h11;
    WriteEn1 = 1'b1; WriteAddr1 = 5'd5; WriteData1 = 32'h22;
    set_rd(5'd5);
    check("coll_bypass", ReadData[DW-1:0], 32'h22);
    step();
    WriteEn0 = 1'b0; WriteEn1 = 1'b0;
    set_rd(5'd5);
    check("coll_stored", ReadData[DW-1:0], 32'h22);

    // Bypass on all three read ports before the edge.
    WriteEn1 = 1'b1; WriteAddr1 = 5'd7; WriteData1 = 32'hA5A5A5A5;
    set_rd(5'd7);
    check("byp_p0", ReadData[0*DW +: DW], 32'hA5A5A5A5);
    check("byp_p1", ReadData[1*DW +: DW], 32'hA5A5A5A5);
    check("byp_p2", ReadData[2*DW +: DW], 32'hA5A5A5A5);
    // Port-0 bypass while port 1 targets another address.
    WriteEn0 = 1'b1; WriteAddr0 = 5'd9; WriteData0 = 32'h77;
    set_rd(5'd9);
    check("byp_w0", ReadData[DW-1:0], 32'h77);
    step();
    WriteEn0 = 1'b0; WriteEn1 = 1'b0;
    set_rd(5'd7);
    check("byp_stored7", ReadData[2*DW +: DW], 32'hA5A5A5A5);
    set_rd(5'd9);
    check("byp_stored9", ReadData[DW-1:0], 32'h77);

    // Fill regs 1..31 with their index.
    for (int a = 1; a < DEPTH; a++) begin
      WriteEn0 = 1'b1; WriteAddr0 = AW'(a); WriteData0 = DW'(a);
      step();
    end
    WriteEn0 = 1'b0;
    set_rd(5'd17);
    check("fill_17", ReadData[DW-1:0], 32'd17);
    set_rd(5'd31);
    check("fill_31", ReadData[DW-1:0], 32'd31);

    // Sweep with racing writes, a mid-sweep request and a request in DONE.
    ClearReq = 1'b1;
    step();
    ClearReq = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    if (ClearBusy) busy_cnt++;
    for (int n = 1; n <= 40; n++) begin
      WriteEn0 = 1'b0;
      ClearReq = 1'b0;
      if (n == 5) begin
        WriteEn0 = 1'b1; WriteAddr0 = 5'd3; WriteData0 = 32'h3;
        set_rd(5'd3);
        check("sweep_byp3", ReadData[DW-1:0], 32'h3);
        set_rd(5'd25);
        check("sweep_unswept25", ReadData[DW-1:0], 32'd25);
      end
      if (n == 10) begin
        WriteEn0 = 1'b1; WriteAddr0 = 5'd20; WriteData0 = 32'h20;
      end
      if (n == 15 || n == 33) ClearReq = 1'b1;
      step();
      if (ClearBusy) busy_cnt++;
      if (ClearDone) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
    end
    WriteEn0 = 1'b0; ClearReq = 1'b0;
    check("sweep_busy_cycles", DW'(busy_cnt), 32'd32);
    check("sweep_done_pulses", DW'(done_cnt), 32'd1);
    check("sweep_done_cycle", DW'(done_at), 32'd32);
    check("sweep_busy_end", DW'(ClearBusy), 32'h0);
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(AW'(a));
      check("sweep_read", ReadData[DW-1:0], (a == 3) ? 32'h3 : 32'h0);
    end

    // Reset during a sweep at pointer 10.
    for (int a = 1; a < DEPTH; a++) begin
      WriteEn1 = 1'b1; WriteAddr1 = AW'(a); WriteData1 = DW'(a + 100);
      step();
    end
    WriteEn1 = 1'b0;
    set_rd(5'd30);
    check("refill_30", ReadData[DW-1:0], 32'd130);
    ClearReq = 1'b1;
    step();
    ClearReq = 1'b0;
    repeat (10) step();
    check("mid_busy", DW'(ClearBusy), 32'h1);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_busy", DW'(ClearBusy), 32'h0);
    check("mid_rst_done", DW'(ClearDone), 32'h0);
    set_rd(5'd30);
    check("mid_rst_read30", ReadData[DW-1:0], 32'h0);
    repeat (2) step();
    Reset_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(AW'(a));
      check("mid_read", ReadData[DW-1:0], 32'h0);
    end
    busy_cnt = 0; done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (ClearBusy) busy_cnt++;
      if (ClearDone) done_cnt++;
    end
    check("mid_no_busy", DW'(busy_cnt), 32'h0);
    check("mid_no_done", DW'(done_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
